// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states, default width
// and the iteration-counter width.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next quotient bit into the partial
// remainder, then subtract the divisor if the result stays non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Keep the remainder MSB so unsigned divisors of 2^(WIDTH-1) or more still divide correctly.
  assign shifted = {rem_in, q_msb};
  assign q_bit   = (shifted >= {1'b0, dvsr});
  assign diff    = shifted[WIDTH-1:0] - dvsr;
  assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// Sequential signed/unsigned divider: remainder drives HI, quotient drives LO.
// WIDTH restoring steps, one sign-fix cycle, then a one-cycle done pulse.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic             a_neg, b_neg;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return -v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_q),
    .q_msb  (quo_q[WIDTH-1]),
    .dvsr   (dvsr_q),
    .rem_out(step_rem),
    .q_bit  (step_bit)
  );

  assign a_neg = div_signed & dividend[WIDTH-1];
  assign b_neg = div_signed & divisor[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          if (divisor == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            quo_d     = a_neg ? neg(dividend) : dividend;
            dvsr_d    = b_neg ? neg(divisor) : divisor;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            rem_d     = '0;
            cnt_d     = CW'(WIDTH);
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = neg_quo_q ? neg(quo_q) : quo_q;
        hi_d    = neg_rem_q ? neg(rem_q) : rem_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
    end
  end

  assign div_hi   = hi_q;
  assign div_lo   = lo_q;
  assign div_busy = (state_q == CALC) || (state_q == FIX);
  assign div_done = (state_q == DONE);
  assign div_zero = zero_q;
endmodule
